// File: rtl/trace_capture_unit_if.sv
// Readout port of the trace capture unit: a valid/ready stream that carries
// the captured {PC, write-back data} entries oldest-first.
// Optional macro TRACE_CYCLE_STAMP_EN adds the per-entry rd_cycle stamp.
interface trace_capture_unit_if #(
  parameter int DATA_W = 32
);
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_data;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [15:0]       rd_cycle;
`endif

  modport master (
    output rd_valid,
    output rd_pc,
    output rd_data,
`ifdef TRACE_CYCLE_STAMP_EN
    output rd_cycle,
`endif
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_pc,
    input  rd_data,
`ifdef TRACE_CYCLE_STAMP_EN
    input  rd_cycle,
`endif
    output rd_ready
  );
endinterface

// File: rtl/trace_capture_unit.sv
// On-chip trace buffer for the Datapath PC / write-back stream.
// While armed it keeps the last DEPTH samples in a circular buffer, freezes
// POST_TRIG samples after a PC-match trigger or a detected halt (PC stuck for
// STALL_LIMIT samples), then drains the survivors oldest-first.
// Optional macro TRACE_CYCLE_STAMP_EN stores a 16-bit cycle stamp per entry
// and presents it on rd.rd_cycle.
module trace_capture_unit #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int POST_TRIG   = 8,
  parameter int STALL_LIMIT = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [DATA_W-1:0]      PCResult,
  input  logic [DATA_W-1:0]      WriteData,
  input  logic                   arm,
  input  logic                   trig_en,
  input  logic [DATA_W-1:0]      trig_pc,
  trace_capture_unit_if.master   rd,
  output logic [1:0]             state,
  output logic                   halted,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = $clog2(STALL_LIMIT + 1);
  localparam int PW    = (PTR_W < 1) ? 1 : PTR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            cur;
  logic [PTR_W-1:0]  wptr, rptr, wptr_nxt, rptr_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic [PW-1:0]     post_cnt;
  logic [SW-1:0]     stall_cnt, run_len;
  logic [DATA_W-1:0] prev_pc;
  logic [DATA_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DATA_W-1:0] load_pc, load_data;
  logic              start, do_write, do_read, pc_match, stall_hit, fire, to_done;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [15:0]       cyc_cnt;
  logic [15:0]       stamp_mem [DEPTH];
  logic [15:0]       load_stamp;
`endif

  assign state = cur;

  // Next-cycle pointer/count bookkeeping, trigger decisions and readout bypass
  always_comb begin
    start     = arm && (cur == IDLE || cur == DONE);
    do_write  = (cur == ARMED) || (cur == POST);
    do_read   = (cur == DONE) && rd.rd_valid && rd.rd_ready && !arm;
    pc_match  = trig_en && (PCResult == trig_pc);
    run_len   = (stall_cnt != '0 && PCResult == prev_pc) ? stall_cnt + SW'(1) : SW'(1);
    stall_hit = (cur == ARMED) && (run_len == SW'(STALL_LIMIT));
    fire      = (cur == ARMED) && (pc_match || stall_hit);
    to_done   = (cur == DONE && !start) || (fire && POST_TRIG == 0) ||
                (cur == POST && post_cnt == PW'(1));
    wptr_nxt  = wptr;
    rptr_nxt  = rptr;
    count_nxt = count;
    if (start) begin
      wptr_nxt  = '0;
      rptr_nxt  = '0;
      count_nxt = '0;
    end else if (do_write) begin
      wptr_nxt = wptr + PTR_W'(1);
      if (count == CNT_W'(DEPTH)) rptr_nxt = rptr + PTR_W'(1);
      else count_nxt = count + CNT_W'(1);
    end else if (do_read) begin
      rptr_nxt  = rptr + PTR_W'(1);
      count_nxt = count - CNT_W'(1);
    end
    if (do_write && rptr_nxt == wptr) begin
      load_pc   = PCResult;
      load_data = WriteData;
    end else begin
      load_pc   = pc_mem[rptr_nxt];
      load_data = data_mem[rptr_nxt];
    end
`ifdef TRACE_CYCLE_STAMP_EN
    load_stamp = (do_write && rptr_nxt == wptr) ? cyc_cnt : stamp_mem[rptr_nxt];
`endif
  end

  // Sample storage; contents are don't-care after reset so no reset branch
  always_ff @(posedge Clk) begin
    if (do_write) begin
      pc_mem[wptr]   <= PCResult;
      data_mem[wptr] <= WriteData;
`ifdef TRACE_CYCLE_STAMP_EN
      stamp_mem[wptr] <= cyc_cnt;
`endif
    end
  end

`ifdef TRACE_CYCLE_STAMP_EN
  // Free-running stamp counter restarted by each accepted arm
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) cyc_cnt <= '0;
    else if (start) cyc_cnt <= '0;
    else cyc_cnt <= cyc_cnt + 16'd1;
  end
`endif

  // Capture FSM plus registered pointers, status and readout outputs
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cur         <= IDLE;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      post_cnt    <= '0;
      stall_cnt   <= '0;
      prev_pc     <= '0;
      halted      <= 1'b0;
      rd.rd_valid <= 1'b0;
      rd.rd_pc    <= '0;
      rd.rd_data  <= '0;
`ifdef TRACE_CYCLE_STAMP_EN
      rd.rd_cycle <= '0;
`endif
    end else begin
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      count <= count_nxt;
      if (do_write) prev_pc <= PCResult;
      case (cur)
        IDLE, DONE: begin
          if (arm) begin
            cur       <= ARMED;
            halted    <= 1'b0;
            stall_cnt <= '0;
          end
        end
        ARMED: begin
          stall_cnt <= run_len;
          if (fire) begin
            if (stall_hit) halted <= 1'b1;
            if (POST_TRIG == 0) begin
              cur <= DONE;
            end else begin
              cur      <= POST;
              post_cnt <= PW'(POST_TRIG);
            end
          end
        end
        POST: begin
          if (post_cnt == PW'(1)) cur <= DONE;
          else post_cnt <= post_cnt - PW'(1);
        end
        default: cur <= IDLE;
      endcase
      if (to_done && count_nxt != '0) begin
        rd.rd_valid <= 1'b1;
        rd.rd_pc    <= load_pc;
        rd.rd_data  <= load_data;
`ifdef TRACE_CYCLE_STAMP_EN
        rd.rd_cycle <= load_stamp;
`endif
      end else begin
        rd.rd_valid <= 1'b0;
      end
    end
  end

endmodule
